// File: rtl/ex_hilo_muldiv.sv
// EX-stage multicycle multiply/divide unit holding the architectural HI/LO registers.
// Multiplies use radix-2 shift-add and divides use restoring division, one bit per edge.
// Signed operands are converted to magnitudes on accept and the sign is fixed up in StFix.
`timescale 1ns/1ps
module ex_hilo_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
  localparam logic [2:0] OpMadd  = 3'b110;
  localparam logic [2:0] OpMsub  = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e             r_state, w_state_next;
  logic [CntW-1:0]    r_cnt;
  logic [2:0]         r_op;
  logic               r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_a_mag, r_b_mag;
  logic [WIDTH-1:0]   r_hi, r_lo;
  // Upper half: partial product / remainder. Lower half: multiplier / dividend-quotient.
  logic [2*WIDTH-1:0] r_acc;
  logic               r_done, r_divzero;

  logic               w_signed, w_is_div, w_is_mt, w_accept, w_div_zero, w_last;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum, w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_prod_signed, w_hilo;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_signed   = (Op == OpMult) | (Op == OpDiv) | (Op == OpMadd) | (Op == OpMsub);
  assign w_is_div   = (Op == OpDiv) | (Op == OpDivu);
  assign w_is_mt    = (Op == OpMthi) | (Op == OpMtlo);
  // Done blocks acceptance so the instruction still held in the Done cycle cannot retrigger.
  assign w_accept   = Start & (r_state == StIdle) & ~r_done & ~Flush;
  assign w_div_zero = w_is_div & (B == '0);
  assign w_a_mag    = (w_signed & A[WIDTH-1]) ? -A : A;
  assign w_b_mag    = (w_signed & B[WIDTH-1]) ? -B : B;
  assign w_last     = (r_cnt == CntW'(WIDTH - 1));

  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a_mag} : '0);
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});
  // Only consumed when w_div_ge, so the result always fits in WIDTH bits.
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_b_mag;

  assign w_hilo        = {r_hi, r_lo};
  assign w_prod_signed = r_neg_q ? -r_acc : r_acc;
  assign w_quo         = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem         = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign Busy    = (r_state != StIdle);
  assign Stall   = Busy | (w_accept & ~w_is_mt);
  assign Done    = r_done;
  assign DivZero = r_divzero;
  assign Hi      = r_hi;
  assign Lo      = r_lo;

  // Next-state: iterate WIDTH edges, one fix-up edge, Flush always returns to idle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_accept & ~w_is_mt & ~w_div_zero) w_state_next = w_is_div ? StDiv : StMul;
      StMul:  if (w_last) w_state_next = StFix;
      StDiv:  if (w_last) w_state_next = StFix;
      StFix:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (Flush) w_state_next = StIdle;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Datapath: operand capture, per-bit iteration, sign fix-up and HI/LO write-back.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      if (Flush) begin
        r_cnt <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_accept) begin
              if (Op == OpMthi) begin
                r_hi <= A;
              end else if (Op == OpMtlo) begin
                r_lo <= A;
              end else if (w_div_zero) begin
                r_done    <= 1'b1;
                r_divzero <= 1'b1;
              end else begin
                r_op    <= Op;
                r_cnt   <= '0;
                r_a_mag <= w_a_mag;
                r_b_mag <= w_b_mag;
                r_neg_q <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                r_neg_r <= w_signed & A[WIDTH-1];
                r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
              end
            end
          end
          StMul: begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            r_cnt <= r_cnt + CntW'(1);
          end
          StDiv: begin
            r_acc <= {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_div_ge};
            r_cnt <= r_cnt + CntW'(1);
          end
          StFix: begin
            unique case (r_op)
              OpMult, OpMultu: {r_hi, r_lo} <= w_prod_signed;
              OpMadd:          {r_hi, r_lo} <= w_hilo + w_prod_signed;
              OpMsub:          {r_hi, r_lo} <= w_hilo - w_prod_signed;
              OpDiv, OpDivu: begin
                r_lo <= w_quo;
                r_hi <= w_rem;
              end
              default: ;
            endcase
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// Directed bench for ex_hilo_muldiv: results, latency, div-by-zero, flush and reset behaviour.
`timescale 1ns/1ps
module tb_ex_hilo_muldiv;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
  localparam logic [2:0] OpMadd  = 3'b110;
  localparam logic [2:0] OpMsub  = 3'b111;

  logic        Clk, Reset, Start, Flush;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Stall, Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int n_checks = 0;
  int n_errors = 0;

  // Per-operation observations filled in by run_mc.
  int   stall_n, busy_n, done_at, n_done;
  logic dz_at_done, stall0, retrig;

  ex_hilo_muldiv #(.WIDTH(32)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .Flush   (Flush),
    .Stall   (Stall),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op like a stalled pipeline would: hold Start through the Done cycle.
  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic run_mc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    stall_n = 0; busy_n = 0; done_at = -1; dz_at_done = 1'b0; stall0 = 1'b0;
    Start = 1'b1; Op = op; A = a; B = b;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (k == 0) stall0 = Stall;
      if (Stall) stall_n++;
      if (Busy) busy_n++;
      if (Done) begin
        done_at    = k;
        dz_at_done = DivZero;
      end
      @(posedge Clk); #1;
      if (done_at >= 0) break;
    end
    Start = 1'b0;
    @(negedge Clk);
    retrig = Busy | Done;
    @(posedge Clk); #1;
  endtask

  task automatic mt_op(input logic [2:0] op, input logic [31:0] a, input string tag);
    Start = 1'b1; Op = op; A = a;
    @(negedge Clk);
    check_eq(tag, 64'(Stall), 64'd0);
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic count_done(input int cycles);
    n_done = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge Clk);
      if (Done) n_done++;
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; Op = '0; A = '0; B = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_eq("reset_hi", 64'(Hi), 64'd0);
    check_eq("reset_lo", 64'(Lo), 64'd0);
    check_eq("reset_busy_done_dz", 64'({Busy, Done, DivZero}), 64'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // MULT -3 * 7 = -21
    run_mc(OpMult, 32'hFFFF_FFFD, 32'd7);
    check_eq("mult_stall_accept", 64'(stall0), 64'd1);
    check_eq("mult_busy_cycles", 64'(busy_n), 64'd33);
    check_eq("mult_stall_cycles", 64'(stall_n), 64'd34);
    check_eq("mult_done_cycle", 64'(done_at), 64'd34);
    check_eq("mult_no_retrigger", 64'(retrig), 64'd0);
    check_eq("mult_hilo", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_mc(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_eq("multu_hilo", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFE_0000_0001);

    // DIV -7 / 2 -> q=-3, r=-1
    run_mc(OpDiv, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_done_cycle", 64'(done_at), 64'd34);
    check_eq("div_dz", 64'(dz_at_done), 64'd0);
    check_eq("div_hilo", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_mc(OpDivu, 32'd100, 32'd7);
    check_eq("divu_hilo", {32'(Hi), 32'(Lo)}, {32'd2, 32'd14});

    run_mc(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("div_ovf_hilo", {32'(Hi), 32'(Lo)}, 64'h0000_0000_8000_0000);

    // Divide by zero after MTHI/MTLO preload
    mt_op(OpMthi, 32'h11, "mthi_stall");
    mt_op(OpMtlo, 32'h22, "mtlo_stall");
    check_eq("mt_hilo", {32'(Hi), 32'(Lo)}, {32'h11, 32'h22});
    run_mc(OpDivu, 32'd5, 32'd0);
    check_eq("dz_done_cycle", 64'(done_at), 64'd1);
    check_eq("dz_flag", 64'(dz_at_done), 64'd1);
    check_eq("dz_busy_cycles", 64'(busy_n), 64'd0);
    check_eq("dz_no_retrigger", 64'(retrig), 64'd0);
    check_eq("dz_hilo", {32'(Hi), 32'(Lo)}, {32'h11, 32'h22});

    // MADD / MSUB accumulate
    mt_op(OpMthi, 32'h0, "mthi0_stall");
    mt_op(OpMtlo, 32'h0, "mtlo0_stall");
    run_mc(OpMadd, 32'd3, 32'd4);
    check_eq("madd1_hilo", {32'(Hi), 32'(Lo)}, 64'd12);
    run_mc(OpMadd, 32'd3, 32'd4);
    check_eq("madd2_hilo", {32'(Hi), 32'(Lo)}, 64'd24);
    run_mc(OpMsub, 32'd1, 32'd30);
    check_eq("msub_hilo", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFA);

    // Flush together with Start while idle: no stall, no accept
    Start = 1'b1; Op = OpMult; A = 32'd5; B = 32'd5; Flush = 1'b1;
    @(negedge Clk);
    check_eq("flush_start_stall", 64'(Stall), 64'd0);
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0;
    @(negedge Clk);
    check_eq("flush_start_busy", 64'(Busy), 64'd0);
    @(posedge Clk); #1;

    // Flush at iteration 10 of a MULT
    Start = 1'b1; Op = OpMult; A = 32'd5; B = 32'd5;
    repeat (10) begin @(posedge Clk); #1; end
    Flush = 1'b1; Start = 1'b0;
    @(posedge Clk); #1;
    Flush = 1'b0;
    @(negedge Clk);
    check_eq("flush_iter_busy_stall", 64'({Busy, Stall}), 64'd0);
    count_done(40);
    check_eq("flush_iter_no_done", 64'(n_done), 64'd0);
    check_eq("flush_iter_hilo", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFA);

    // Flush coinciding with the fix-up edge
    Start = 1'b1; Op = OpMultu; A = 32'd2; B = 32'd3;
    repeat (33) begin @(posedge Clk); #1; end
    @(negedge Clk);
    check_eq("fix_cycle_busy", 64'(Busy), 64'd1);
    Flush = 1'b1; Start = 1'b0;
    @(posedge Clk); #1;
    Flush = 1'b0;
    count_done(40);
    check_eq("flush_fix_no_done", 64'(n_done), 64'd0);
    check_eq("flush_fix_hilo", {32'(Hi), 32'(Lo)}, 64'hFFFF_FFFF_FFFF_FFFA);

    // Reset in the middle of an operation
    Start = 1'b1; Op = OpMult; A = 32'd2; B = 32'd3;
    repeat (5) begin @(posedge Clk); #1; end
    Start = 1'b0; Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check_eq("midreset_hilo", {32'(Hi), 32'(Lo)}, 64'd0);
    check_eq("midreset_busy", 64'(Busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
